// File: rtl/dp_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, mux selects,
// status flag positions and memory FSM states.
package dp_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SHL   = 3'd5;
    localparam logic [2:0] ALU_SHR   = 3'd6;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    localparam logic [1:0] IN2_B    = 2'd0;
    localparam logic [1:0] IN2_IMMS = 2'd1;
    localparam logic [1:0] IN2_IMMB = 2'd2;
    localparam logic [1:0] IN2_ZERO = 2'd3;

    localparam logic [1:0] DIN_ALU  = 2'd0;
    localparam logic [1:0] DIN_MDR  = 2'd1;
    localparam logic [1:0] DIN_IMMB = 2'd2;
    localparam logic [1:0] DIN_PC   = 2'd3;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_IMMJ = 2'd1;
    localparam logic [1:0] PC_A    = 2'd2;
    localparam logic [1:0] PC_REL  = 2'd3;

    localparam logic [1:0] ADDR_PC   = 2'd0;
    localparam logic [1:0] ADDR_A    = 2'd1;
    localparam logic [1:0] ADDR_IMMB = 2'd2;
    localparam logic [1:0] ADDR_ALU  = 2'd3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/datapath_hs_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// all registers cleared by the asynchronous active-low reset.
module dp_regfile #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [ADDR-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ADDR-1:0]  raddr1_i,
    input  logic [ADDR-1:0]  raddr2_i,
    output logic [WIDTH-1:0] rdata1_o,
    output logic [WIDTH-1:0] rdata2_o
);

    logic [WIDTH-1:0] regs_q [2**ADDR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/datapath_hs.sv
// Multicycle CPU datapath with a single-outstanding req/ack memory port.
// Define DP_WATCHDOG_EN to abort transactions not acked within TIMEOUT cycles.
module datapath_hs
    import dp_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int REG_ADDR_SIZE = 3,
    parameter int ALU_OP_SIZE   = 3,
    parameter int TIMEOUT       = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           alu_in2_mux,
    input  logic [1:0]           data_in_mux,
    input  logic [1:0]           pc_mux,
    input  logic [1:0]           addr_mux,
    input  logic                 mem_out_mux,
    input  logic                 ab_write,
    input  logic                 alu_out_write,
    input  logic                 status_write,
    input  logic                 reg_write,
    input  logic                 pc_write,
    input  logic                 ir_write,
    input  logic                 mem_start,
    input  logic                 mem_we_in,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 busy,
    output logic                 mem_err,
    output logic [4:0]           opcode,
    output logic [WORD_SIZE-1:0] status
);

    localparam int W  = WORD_SIZE;
    localparam int RA = REG_ADDR_SIZE;

    logic [W-1:0] pc_q, ir_q, mdr_q, a_q, b_q, alu_out_q, status_q;
    logic [W-1:0] addr_q, wdata_q;
    logic         we_q;
    mem_state_e   state_q;

    logic [RA-1:0]          rd, rs1, rs2;
    logic [ALU_OP_SIZE-1:0] alu_op;
    logic [W-1:0] imm_j, imm_b, imm_s, imm_b_sx;
    logic [W-1:0] rf_rd1, rf_rd2, rf_wdata;
    logic [W-1:0] alu_in2, alu_res, pc_d, addr_d, status_d;
    logic [W:0]   sum_w, shl_w, shr_w;
    logic         alu_c, alu_v;

    assign rd       = ir_q[W-6 -: RA];
    assign rs1      = ir_q[W-6-RA -: RA];
    assign rs2      = ir_q[W-6-2*RA -: RA];
    assign alu_op   = ir_q[ALU_OP_SIZE-1:0];
    assign imm_j    = {5'b0, ir_q[W-6:0]};
    assign imm_b    = {{(W-8){1'b0}}, ir_q[7:0]};
    assign imm_b_sx = {{(W-8){ir_q[7]}}, ir_q[7:0]};
    assign imm_s    = {{(W-5){1'b0}}, ir_q[4:0]};

    dp_regfile #(.WIDTH(W), .ADDR(RA)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (reg_write),
        .waddr_i  (rd),
        .wdata_i  (rf_wdata),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    always_comb begin
        alu_in2  = b_q;
        rf_wdata = alu_out_q;
        pc_d     = pc_q + 1'b1;
        addr_d   = pc_q;
        unique case (alu_in2_mux)
            IN2_B:    alu_in2 = b_q;
            IN2_IMMS: alu_in2 = imm_s;
            IN2_IMMB: alu_in2 = imm_b;
            default:  alu_in2 = '0;
        endcase
        unique case (data_in_mux)
            DIN_ALU:  rf_wdata = alu_out_q;
            DIN_MDR:  rf_wdata = mdr_q;
            DIN_IMMB: rf_wdata = imm_b;
            default:  rf_wdata = pc_q;
        endcase
        unique case (pc_mux)
            PC_INC:  pc_d = pc_q + 1'b1;
            PC_IMMJ: pc_d = imm_j;
            PC_A:    pc_d = a_q;
            default: pc_d = pc_q + imm_b_sx;
        endcase
        unique case (addr_mux)
            ADDR_PC:   addr_d = pc_q;
            ADDR_A:    addr_d = a_q;
            ADDR_IMMB: addr_d = imm_b;
            default:   addr_d = alu_out_q;
        endcase
    end

    // SUB is a + ~b + 1, so the carry out is set exactly when no borrow occurs
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_w   = '0;
        shl_w   = {1'b0, a_q} << alu_in2[3:0];
        shr_w   = {a_q, 1'b0} >> alu_in2[3:0];
        case (alu_op)
            ALU_ADD: begin
                sum_w   = {1'b0, a_q} + {1'b0, alu_in2};
                alu_res = sum_w[W-1:0];
                alu_c   = sum_w[W];
                alu_v   = (a_q[W-1] == alu_in2[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            ALU_SUB: begin
                sum_w   = {1'b0, a_q} + {1'b0, ~alu_in2} + {{W{1'b0}}, 1'b1};
                alu_res = sum_w[W-1:0];
                alu_c   = sum_w[W];
                alu_v   = (a_q[W-1] != alu_in2[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            ALU_AND: alu_res = a_q & alu_in2;
            ALU_OR:  alu_res = a_q | alu_in2;
            ALU_XOR: alu_res = a_q ^ alu_in2;
            ALU_SHL: begin
                alu_res = shl_w[W-1:0];
                alu_c   = shl_w[W];
            end
            ALU_SHR: begin
                alu_res = shr_w[W:1];
                alu_c   = shr_w[0];
            end
            default: alu_res = alu_in2;
        endcase
        status_d         = '0;
        status_d[FLAG_Z] = (alu_res == '0);
        status_d[FLAG_N] = alu_res[W-1];
        status_d[FLAG_C] = alu_c;
        status_d[FLAG_V] = alu_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            status_q  <= '0;
        end else begin
            if (pc_write)      pc_q      <= pc_d;
            if (ir_write)      ir_q      <= mdr_q;
            if (ab_write)      a_q       <= rf_rd1;
            if (ab_write)      b_q       <= rf_rd2;
            if (alu_out_write) alu_out_q <= alu_res;
            if (status_write)  status_q  <= status_d;
        end
    end

`ifdef DP_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Address, data and direction are frozen at mem_start and held until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mdr_q   <= '0;
`ifdef DP_WATCHDOG_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_start) begin
                        state_q <= S_REQ;
                        addr_q  <= addr_d;
                        wdata_q <= mem_out_mux ? a_q : b_q;
                        we_q    <= mem_we_in;
`ifdef DP_WATCHDOG_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                default: begin
                    if (mem_ack) begin
                        state_q <= S_IDLE;
                        we_q    <= 1'b0;
                        if (!we_q) mdr_q <= mem_rdata;
                    end
`ifdef DP_WATCHDOG_EN
                    else if (cnt_q == CNT_LAST) begin
                        state_q <= S_IDLE;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

`ifdef DP_WATCHDOG_EN
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_req   = (state_q == S_REQ);
    assign busy      = (state_q == S_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign opcode    = ir_q[W-1 -: 5];
    assign status    = status_q;

endmodule
